// File: rtl/data_bus_sender_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_sender_pkg
// Shared definitions for the data bus sender: launch FSM state encoding and
// the sizing helper for the optional handshake watchdog counter.
// -----------------------------------------------------------------------------
package data_bus_sender_pkg;

   // Launch FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DROP = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   // Counter width able to hold the value timeout_cycles itself
   function automatic int unsigned wd_cnt_width(input int unsigned timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage : data_bus_sender_pkg

// File: rtl/bus_hsk_watchdog.sv
// -----------------------------------------------------------------------------
// bus_hsk_watchdog
// Saturating cycle counter with a sticky timeout flag, used to flag a
// synchronizer handshake that never completes. Only compiled when
// DATA_BUS_SENDER_WATCHDOG_EN is defined, which is also the only build that
// instantiates it.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   i_clear   in   restart the count (does not clear the flag)
//   i_enable  in   count this cycle
//   o_timeout out  sticky, set when the count reaches TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
`ifdef DATA_BUS_SENDER_WATCHDOG_EN
module bus_hsk_watchdog
   import data_bus_sender_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_timeout
);

   localparam int unsigned CNT_W = wd_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;

   // Counter saturates at the limit; the flag is set on the step that reaches it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (r_cnt == (CNT_MAX - CNT_W'(1))) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign o_timeout = r_timeout;

endmodule : bus_hsk_watchdog
`endif

// File: rtl/data_bus_sender.sv
// -----------------------------------------------------------------------------
// data_bus_sender
// Source-domain launcher for the handshake data bus crossing. Captures one
// upstream word into a launch register, requests the synchronizer and keeps
// the word stable until the synchronizer has gone busy (tready low) and come
// back idle (tready high), i.e. the destination has captured it.
//
// Optional watchdog: define DATA_BUS_SENDER_WATCHDOG_EN to count cycles spent
// outside IDLE and raise a sticky timeout_err at TIMEOUT_CYCLES. Without it,
// timeout_err is tied low.
//
// Ports:
//   aclk         in   source-domain clock
//   arstn        in   asynchronous active-low reset
//   s_tvalid     in   upstream word valid
//   s_tready     out  upstream ready (registered)
//   s_tdata      in   upstream word
//   sync_tvalid  out  request to synchronizer (registered)
//   sync_tready  in   synchronizer idle / able to accept
//   sync_tdata   out  launch register
//   busy         out  high outside IDLE (registered)
//   timeout_err  out  sticky watchdog flag
// -----------------------------------------------------------------------------
module data_bus_sender
   import data_bus_sender_pkg::*;
#(
   parameter int unsigned BUS_WIDTH      = 8,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                 aclk,
   input  logic                 arstn,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   input  logic [BUS_WIDTH-1:0] s_tdata,
   output logic                 sync_tvalid,
   input  logic                 sync_tready,
   output logic [BUS_WIDTH-1:0] sync_tdata,
   output logic                 busy,
   output logic                 timeout_err
);

   // Reject a watchdog limit that can never be reached
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("data_bus_sender: TIMEOUT_CYCLES must be at least 1");
   end

   state_e               r_state;
   logic                 r_s_tready;
   logic                 r_sync_tvalid;
   logic                 r_busy;
   logic [BUS_WIDTH-1:0] r_sync_tdata;
   logic                 w_capture;

   // Upstream handshake; r_s_tready is only ever high in IDLE
   assign w_capture = (r_state == ST_IDLE) && s_tvalid && r_s_tready;

   // Launch FSM; r_s_tready doubles as the one-cycle reset-settle register
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         r_state       <= ST_IDLE;
         r_s_tready    <= 1'b0;
         r_sync_tvalid <= 1'b0;
         r_busy        <= 1'b0;
         r_sync_tdata  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_s_tready <= 1'b1;
               if (w_capture) begin
                  r_sync_tdata  <= s_tdata;
                  r_sync_tvalid <= 1'b1;
                  r_s_tready    <= 1'b0;
                  r_busy        <= 1'b1;
                  r_state       <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (r_sync_tvalid && sync_tready) begin
                  r_sync_tvalid <= 1'b0;
                  r_state       <= ST_DROP;
               end
            end
            // tready still high here is the pre-handshake idle, not an ack
            ST_DROP: begin
               if (!sync_tready) begin
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (sync_tready) begin
                  r_busy     <= 1'b0;
                  r_s_tready <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_tready    = r_s_tready;
   assign sync_tvalid = r_sync_tvalid;
   assign sync_tdata  = r_sync_tdata;
   assign busy        = r_busy;

`ifdef DATA_BUS_SENDER_WATCHDOG_EN
   logic w_timeout;

   // Count restarts on capture and runs for every cycle outside IDLE
   bus_hsk_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (aclk),
      .rst_n     (arstn),
      .i_clear   (w_capture),
      .i_enable  (r_busy),
      .o_timeout (w_timeout)
   );

   assign timeout_err = w_timeout;
`else
   assign timeout_err = 1'b0;
`endif

endmodule : data_bus_sender

// File: tb/tb_data_bus_sender.sv
// -----------------------------------------------------------------------------
// tb_data_bus_sender
// Directed bench with a scoreboard: every word offered upstream is queued,
// and a monitor pops and compares whenever the DUT handshakes with the
// synchronizer model. The monitor also checks that the launch register holds
// the last accepted word for as long as the DUT is busy.
// -----------------------------------------------------------------------------
module tb_data_bus_sender;

   localparam int unsigned BW = 8;
   localparam int unsigned TO = 16;
`ifdef DATA_BUS_SENDER_WATCHDOG_EN
   localparam logic WD_ON = 1'b1;
`else
   localparam logic WD_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          arstn;
   logic          s_tvalid;
   logic          s_tready;
   logic [BW-1:0] s_tdata;
   logic          sync_tvalid;
   logic          sync_tready;
   logic [BW-1:0] sync_tdata;
   logic          busy;
   logic          timeout_err;

   logic          sync_auto = 1'b0;
   logic          man_rdy   = 1'b1;
   logic          auto_rdy  = 1'b1;

   int            checks   = 0;
   int            errors   = 0;
   int            n_pushed = 0;
   int            n_recv   = 0;
   int            wait_cnt;
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] exp_launch = '0;
   logic [BW-1:0] mon_word;

   assign sync_tready = sync_auto ? auto_rdy : man_rdy;

   data_bus_sender #(
      .BUS_WIDTH      (BW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .aclk        (clk),
      .arstn       (arstn),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tdata     (s_tdata),
      .sync_tvalid (sync_tvalid),
      .sync_tready (sync_tready),
      .sync_tdata  (sync_tdata),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [BW-1:0] w);
      exp_q.push_back(w);
      n_pushed++;
   endtask

   // Monitor: launch-register stability and scoreboard pops on handshakes
   always @(negedge clk) begin
      if (arstn && s_tvalid && s_tready) exp_launch = s_tdata;
      if (arstn && busy) check("launch_stable", 32'(sync_tdata), 32'(exp_launch));
      if (arstn && sync_tvalid && sync_tready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_handshake: got word %0h with no word pending at %0t",
                     sync_tdata, $time);
         end else begin
            mon_word = exp_q.pop_front();
            check("handshake_data", 32'(sync_tdata), 32'(mon_word));
            n_recv++;
         end
      end
   end

   // Synchronizer model: after a handshake, optionally stay idle a few cycles,
   // go busy for 1..21 cycles, then return idle
   initial begin
      forever begin
         @(negedge clk);
         if (sync_auto && arstn && sync_tvalid && sync_tready) begin
            int unsigned pre;
            int unsigned low;
            pre = $urandom_range(0, 3);
            low = $urandom_range(0, 20);
            tick();
            repeat (pre) tick();
            auto_rdy = 1'b0;
            repeat (low + 1) tick();
            auto_rdy = 1'b1;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish at %0t", $time);
      $fatal(1, "tb_data_bus_sender time limit");
   end

   initial begin
      arstn    = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = 8'hA5;
      man_rdy  = 1'b1;
      repeat (3) tick();

      // Reset values
      check("rst_s_tready",    32'(s_tready),    32'd0);
      check("rst_sync_tvalid", 32'(sync_tvalid), 32'd0);
      check("rst_sync_tdata",  32'(sync_tdata),  32'd0);
      check("rst_busy",        32'(busy),        32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);

      // Release with a word already waiting
      arstn = 1'b1;
      push_word(8'hA5);
      check("settle_s_tready_low", 32'(s_tready), 32'd0);
      tick();
      check("settle_s_tready_high", 32'(s_tready), 32'd1);
      check("settle_busy", 32'(busy), 32'd0);
      tick();
      check("cap_sync_tvalid", 32'(sync_tvalid), 32'd1);
      check("cap_sync_tdata",  32'(sync_tdata),  32'hA5);
      check("cap_busy",        32'(busy),        32'd1);
      check("cap_s_tready",    32'(s_tready),    32'd0);
      s_tvalid = 1'b0;
      tick();
      check("hs_sync_tvalid_fall", 32'(sync_tvalid), 32'd0);
      man_rdy = 1'b0;
      repeat (6) begin
         tick();
         check("hold_sync_tdata", 32'(sync_tdata), 32'hA5);
         check("hold_s_tready",   32'(s_tready),   32'd0);
      end
      man_rdy = 1'b1;
      tick();
      check("ack_s_tready", 32'(s_tready), 32'd1);
      check("ack_busy",     32'(busy),     32'd0);

      // Synchronizer not ready during SEND: request held, upstream blocked
      man_rdy  = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = 8'h77;
      push_word(8'h77);
      tick();
      check("bp_cap_sync_tvalid", 32'(sync_tvalid), 32'd1);
      s_tdata = 8'h99;
      repeat (10) begin
         tick();
         check("bp_sync_tvalid", 32'(sync_tvalid), 32'd1);
         check("bp_busy",        32'(busy),        32'd1);
         check("bp_s_tready",    32'(s_tready),    32'd0);
         check("bp_sync_tdata",  32'(sync_tdata),  32'h77);
      end
      s_tvalid = 1'b0;
      man_rdy  = 1'b1;
      tick();
      check("bp_hs_sync_tvalid", 32'(sync_tvalid), 32'd0);
      man_rdy = 1'b0;
      tick();
      man_rdy = 1'b1;
      tick();
      check("bp_done_busy",     32'(busy),     32'd0);
      check("bp_done_s_tready", 32'(s_tready), 32'd1);

      // Reset asserted while in HOLD
      s_tvalid = 1'b1;
      s_tdata  = 8'h55;
      push_word(8'h55);
      tick();
      s_tvalid = 1'b0;
      tick();
      man_rdy = 1'b0;
      tick();
      check("hold_before_rst_busy", 32'(busy), 32'd1);
      #2 arstn = 1'b0;
      #1;
      check("mid_rst_s_tready",    32'(s_tready),    32'd0);
      check("mid_rst_sync_tvalid", 32'(sync_tvalid), 32'd0);
      check("mid_rst_sync_tdata",  32'(sync_tdata),  32'd0);
      check("mid_rst_busy",        32'(busy),        32'd0);
      check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
      tick();
      tick();
      arstn   = 1'b1;
      man_rdy = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = 8'h3C;
      push_word(8'h3C);
      tick();
      tick();
      check("post_rst_sync_tvalid", 32'(sync_tvalid), 32'd1);
      check("post_rst_sync_tdata",  32'(sync_tdata),  32'h3C);
      s_tvalid = 1'b0;
      tick();
      man_rdy = 1'b0;
      tick();
      man_rdy = 1'b1;
      tick();
      check("post_rst_done_busy", 32'(busy), 32'd0);

      // Back-to-back words with a randomly delayed synchronizer
      sync_auto = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 8'(i);
         push_word(8'(i));
         wait_cnt = 0;
         while (!s_tready && wait_cnt < 200) begin
            tick();
            wait_cnt++;
         end
         if (!s_tready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %0h not accepted within 200 cycles", i);
         end
         tick();
      end
      s_tvalid = 1'b0;
      wait_cnt = 0;
      while ((busy || exp_q.size() != 0) && wait_cnt < 500) begin
         tick();
         wait_cnt++;
      end
      check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
      check("b2b_delivered",   32'(n_recv),       32'(n_pushed));
      check("b2b_idle",        32'(busy),         32'd0);
      sync_auto = 1'b0;
      man_rdy   = 1'b1;

      // Fresh reset so the sticky watchdog flag starts clear
      arstn = 1'b0;
      tick();
      arstn = 1'b1;
      tick();
      check("wd_pre_timeout_err", 32'(timeout_err), 32'd0);

      // Synchronizer never returns in HOLD
      s_tvalid = 1'b1;
      s_tdata  = 8'hE7;
      push_word(8'hE7);
      tick();
      s_tvalid = 1'b0;
      tick();
      man_rdy = 1'b0;
      for (int c = 2; c <= 15; c++) begin
         tick();
         check("wd_before_limit", 32'(timeout_err), 32'd0);
      end
      tick();
      check("wd_at_limit", 32'(timeout_err), 32'(WD_ON));
      repeat (5) tick();
      check("wd_sticky",     32'(timeout_err), 32'(WD_ON));
      check("wd_still_busy", 32'(busy),        32'd1);
      man_rdy = 1'b1;
      tick();
      check("wd_release_busy",  32'(busy),        32'd0);
      check("wd_sticky_idle",   32'(timeout_err), 32'(WD_ON));
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_data_bus_sender

// File: doc/data_bus_sender.md
# data_bus_sender

Single-clock source-side launcher for the handshake-based data bus crossing. Accepts words on a valid/ready stream interface, holds each word stable in a launch register and drives the valid/ready handshake of the pulse synchronizer until the destination domain has captured the word. Sits in the source clock domain directly in front of the data bus synchronizer and guarantees the data-stability rule that the crossing relies on.

## Interface
- BUS_WIDTH, 8, data word width
- TIMEOUT_CYCLES, 256, watchdog limit in cycles (used only with the watchdog macro)

- aclk  input  1  source-domain clock
- arstn  input  1  asynchronous active-low reset
- s_tvalid  input  1  upstream word valid
- s_tready  output  1  upstream ready, registered
- s_tdata  input  BUS_WIDTH  upstream word
- sync_tvalid  output  1  request to synchronizer, registered
- sync_tready  input  1  synchronizer idle and able to accept
- sync_tdata  output  BUS_WIDTH  launch register, stable from capture until return to IDLE
- busy  output  1  high in any state other than IDLE
- timeout_err  output  1  sticky watchdog flag; constant 0 without the macro

## Operation
- One clock (aclk); asynchronous active-low reset (arstn). All state resets asynchronously, releases synchronously.
- FSM states: IDLE, SEND, DROP, HOLD.
  - IDLE: s_tready=1. On s_tvalid&&s_tready: sync_tdata<=s_tdata, go SEND.
  - SEND: sync_tvalid=1. On sync_tvalid&&sync_tready: go DROP; sync_tvalid falls next cycle.
  - DROP: wait for sync_tready==0 (synchronizer busy), then go HOLD.
  - HOLD: wait for sync_tready==1 (destination captured, ack returned), then go IDLE.
- sync_tdata is never written outside IDLE capture; upstream backpressured (s_tready=0) in SEND/DROP/HOLD.
- busy = (state!=IDLE).
- sync_tready already low on entry to DROP or high on entry to HOLD: transition on that same cycle's sample, no extra wait.
- sync_tready high in DROP is not treated as ack; only a 0 then 1 sequence releases the launch register.
- Reset mid-operation: FSM to IDLE, sync_tvalid=0, word in flight discarded; destination may still receive the pulse already in the synchronizer (system-level reset covers both domains).

## Timing
- Reset values: s_tready=0, sync_tvalid=0, sync_tdata=0, busy=0, timeout_err=0.
- s_tready rises in the first cycle after arstn release (one-cycle reset-settle register), then follows state==IDLE.
- Capture at cycle N -> sync_tvalid=1 at N+1.
- Handshake at cycle M -> sync_tvalid=0 at M+1.
- sync_tready returns high at cycle K in HOLD -> s_tready=1 at K+1; next word captured at K+1 at the earliest.
- Throughput: one word per synchronizer round trip plus 3 cycles minimum.

## Configuration
- DATA_BUS_SENDER_WATCHDOG_EN defined: counter clears on entry to SEND, increments each cycle in SEND/DROP/HOLD, saturates; reaching TIMEOUT_CYCLES sets timeout_err, which stays 1 until arstn. No abort, FSM continues waiting.
- Not defined: no counter logic, timeout_err tied to 0, TIMEOUT_CYCLES ignored.

## Structure
- Shared package: FSM state encoding constants (IDLE=2'd0, SEND=2'd1, DROP=2'd2, HOLD=2'd3) and the watchdog counter width function (clog2 of TIMEOUT_CYCLES+1).
- One sub-module: bus_hsk_watchdog (clear, enable, saturating counter, sticky flag), instantiated only under DATA_BUS_SENDER_WATCHDOG_EN.

## Test plan
- Reset release with s_tvalid=1, s_tdata=8'hA5 -> s_tready=0 first cycle, capture next cycle, sync_tdata=8'hA5, sync_tvalid=1 one cycle after capture.
- Synchronizer model: sync_tready drops 1 cycle after handshake, returns 6 cycles later -> sync_tdata held 8'hA5 throughout, s_tready=1 the cycle after return.
- Back-to-back words 8'h01..8'h10 with random sync_tready delays 0-20 -> all 16 delivered in order, none duplicated, sync_tdata never changes outside IDLE.
- sync_tready held 0 during SEND for 10 cycles -> sync_tvalid stays 1, no capture of new upstream data, busy=1.
- arstn asserted in HOLD -> all outputs at reset values immediately; after release, next word 8'h3C launched normally.
- Watchdog macro on, TIMEOUT_CYCLES=16, sync_tready never returns in HOLD -> timeout_err=1 at cycle 16 after SEND entry, stays 1; macro off -> timeout_err constant 0.
